hazard_ctrl: RTL and testbench

Parametrised data/control hazard controller for the RV32 pipeline. It replaces the fixed, always-inactive `hold` and the unforwarded register reads in the core top. It tracks destination registers of instructions in flight across `DEPTH` post-decode stages, forwards the youngest in-flight result to the ID-stage operands, and stalls on load-use. It also inserts a configurable number of bubbles after a taken jump. It sits between InstructionDecode/Registers and Excute, and drives `hold` to InstFetch, Registers and MemoryAccess.

---
 rtl/core_pkg.sv | 30 +++
 rtl/operand_fwd.sv | 40 ++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32 core definitions: widths, forward-select encodings, and the
// in-flight destination tracker entry.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int FWD_W  = 3;

  // Operand source select: regfile, or result of post-decode stage k (k+1)
  localparam logic [FWD_W-1:0] FWD_RF   = 3'd0;
  localparam logic [FWD_W-1:0] FWD_STG0 = 3'd1;
  localparam logic [FWD_W-1:0] FWD_STG1 = 3'd2;
  localparam logic [FWD_W-1:0] FWD_STG2 = 3'd3;
  localparam logic [FWD_W-1:0] FWD_STG3 = 3'd4;

  // One in-flight instruction that will write a register
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } trk_entry_t;

  localparam int TRK_W = $bits(trk_entry_t);

  // Select code for a forward from tracked stage k
  function automatic logic [FWD_W-1:0] fwd_stage_sel(input int k);
    return FWD_STG0 + FWD_W'(k);
  endfunction

endpackage

// File: rtl/operand_fwd.sv
// Per-operand forwarding: picks the youngest in-flight producer of the
// source register, muxes its stage result, and flags a load-use hazard when
// that producer is a load whose data is not yet available.
module operand_fwd
  import core_pkg::*;
#(
  parameter int XLEN             = core_pkg::XLEN,
  parameter int REG_AW           = core_pkg::REG_AW,
  parameter int DEPTH            = 2,
  parameter int LOAD_READY_STAGE = 1
) (
  input  logic [DEPTH*TRK_W-1:0] i_trk,
  input  logic [DEPTH*XLEN-1:0]  i_stage_data,
  input  logic [REG_AW-1:0]      i_rs,
  input  logic                   i_rs_used,
  input  logic [XLEN-1:0]        i_rf_data,
  output logic [FWD_W-1:0]       o_sel,
  output logic [XLEN-1:0]        o_data,
  output logic                   o_load_use
);

  trk_entry_t w_ent;

  // Priority match: scan oldest to youngest so the lowest stage index wins
  always_comb begin
    o_sel      = FWD_RF;
    o_data     = i_rf_data;
    o_load_use = 1'b0;
    w_ent      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_ent = i_trk[k*TRK_W +: TRK_W];
      if (i_rs_used && (i_rs != '0) && w_ent.vld && (w_ent.rd == i_rs)) begin
        o_sel      = fwd_stage_sel(k);
        o_data     = i_stage_data[k*XLEN +: XLEN];
        o_load_use = w_ent.is_load && (k < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Data/control hazard controller: tracks in-flight destination registers,
// forwards the youngest result to ID operands, stalls on load-use and
// inserts bubbles after a taken jump.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int XLEN             = core_pkg::XLEN,
  parameter int REG_AW           = core_pkg::REG_AW,
  parameter int DEPTH            = 2,
  parameter int LOAD_READY_STAGE = 1,
  parameter int FLUSH_CYCLES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_vld,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  id_rd_wr,
  input  logic                  id_is_load,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic                  jump_flag,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [2:0]            fwd_rs1_sel,
  output logic [2:0]            fwd_rs2_sel,
  output logic                  hold,
  output logic                  flush
);

  trk_entry_t             r_trk [DEPTH];
  logic [2:0]             r_fcnt;
  logic [DEPTH*TRK_W-1:0] w_trk_flat;
  trk_entry_t             w_new;
  logic                   w_lu1;
  logic                   w_lu2;

  // Flatten tracker for the per-operand matchers
  always_comb begin
    w_trk_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_trk_flat[k*TRK_W +: TRK_W] = r_trk[k];
    end
  end

  operand_fwd #(
    .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY_STAGE(LOAD_READY_STAGE)
  ) u_fwd_rs1 (
    .i_trk(w_trk_flat), .i_stage_data(stage_data), .i_rs(id_rs1),
    .i_rs_used(id_rs1_used), .i_rf_data(rf_rs1_data),
    .o_sel(fwd_rs1_sel), .o_data(rs1_data), .o_load_use(w_lu1)
  );

  operand_fwd #(
    .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY_STAGE(LOAD_READY_STAGE)
  ) u_fwd_rs2 (
    .i_trk(w_trk_flat), .i_stage_data(stage_data), .i_rs(id_rs2),
    .i_rs_used(id_rs2_used), .i_rf_data(rf_rs2_data),
    .o_sel(fwd_rs2_sel), .o_data(rs2_data), .o_load_use(w_lu2)
  );

  // Flush outranks a stall; a held or killed ID instruction enters EX as a bubble
  always_comb begin
    flush       = jump_flag | (r_fcnt != 3'd0);
    hold        = id_vld & (w_lu1 | w_lu2) & ~flush;
    w_new.vld   = id_vld & id_rd_wr & (id_rd != '0) & ~hold & ~flush;
    w_new.rd    = id_rd;
    w_new.is_load = id_is_load;
  end

  // Tracker shift register: entry 0 is EX, older entries move down each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_trk[k] <= '0;
      end
    end else begin
      r_trk[0] <= w_new;
      for (int k = 1; k < DEPTH; k++) begin
        r_trk[k] <= r_trk[k-1];
      end
    end
  end

  // Flush counter: reloads on every jump, then counts the remaining bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt <= 3'd0;
    end else if (jump_flag) begin
      r_fcnt <= 3'(FLUSH_CYCLES - 1);
    end else if (r_fcnt != 3'd0) begin
      r_fcnt <= r_fcnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue of expected outputs.
module tb_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_vld, id_rs1_used, id_rs2_used, id_rd_wr, id_is_load, jump_flag;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [2:0]        fwd_rs1_sel, fwd_rs2_sel;
  logic              hold, flush;

  localparam logic [31:0] RF1 = 32'hAAAA_0001;
  localparam logic [31:0] RF2 = 32'hBBBB_0002;
  localparam logic [31:0] S0  = 32'h0000_0010;
  logic [31:0] s1;

  typedef struct {
    string       tag;
    logic        hold;
    logic        flush;
    logic [2:0]  sel1;
    logic [31:0] d1;
    logic        dc1;
    logic [2:0]  sel2;
    logic [31:0] d2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  hazard_ctrl #(
    .XLEN(32), .REG_AW(5), .DEPTH(DEPTH), .LOAD_READY_STAGE(1), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data), .stage_data(stage_data), .jump_flag(jump_flag),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel), .hold(hold), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic jmp);
    id_vld = vld; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_wr = wr; id_is_load = ld; jump_flag = jmp;
    stage_data = {s1, S0};
  endtask

  task automatic expect_out(input string tag, input logic h, input logic f,
                            input logic [2:0] sel1, input logic [31:0] d1, input logic dc1,
                            input logic [2:0] sel2, input logic [31:0] d2);
    exp_t e;
    e.tag = tag; e.hold = h; e.flush = f; e.sel1 = sel1; e.d1 = d1; e.dc1 = dc1;
    e.sel2 = sel2; e.d2 = d2;
    sb.push_back(e);
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".hold"},  32'(hold),  32'(e.hold));
      chk({e.tag, ".flush"}, 32'(flush), 32'(e.flush));
      if (!e.dc1) begin
        chk({e.tag, ".sel1"}, 32'(fwd_rs1_sel), 32'(e.sel1));
        chk({e.tag, ".d1"},   rs1_data, e.d1);
      end
      chk({e.tag, ".sel2"}, 32'(fwd_rs2_sel), 32'(e.sel2));
      chk({e.tag, ".d2"},   rs2_data, e.d2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rf_rs1_data = RF1; rf_rs2_data = RF2;
    s1 = 32'h0000_5555;
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_out("reset", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    rst = 1'b0;

    // addi x5 (reads x0)
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    expect_out("addi_x5", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    // add x6,x5,x5 : back-to-back forward from EX
    drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    expect_out("b2b", 0, 0, 1, S0, 0, 1, S0);
    sample();
    // writes x7, reads x5 now in stage 1
    drive(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0);
    expect_out("dist2_x5", 0, 0, 2, 32'h0000_5555, 0, 0, RF2);
    sample();
    // unrelated instruction writing x10
    drive(1, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0, 0);
    expect_out("nomatch", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    // read x7 (stage 1) and x10 (stage 0)
    s1 = 32'h0000_ABCD;
    drive(1, 5'd7, 1, 5'd10, 1, 5'd11, 1, 0, 0);
    expect_out("dist2_x7", 0, 0, 2, 32'h0000_ABCD, 0, 1, S0);
    sample();
    // two back-to-back writers of x7
    drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
    expect_out("wr_x7a", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
    expect_out("wr_x7b", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    // x7 in both stages: youngest wins; this one writes x0
    drive(1, 5'd7, 1, 5'd7, 1, 5'd0, 1, 0, 0);
    expect_out("youngest", 0, 0, 1, S0, 0, 1, S0);
    sample();
    // x0 read and an unused rs2 that would match x7 in stage 1
    drive(1, 5'd0, 1, 5'd7, 0, 5'd0, 0, 0, 0);
    expect_out("x0_unused", 0, 0, 0, RF1, 0, 0, RF2);
    sample();

    // lw x8
    drive(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0);
    expect_out("lw_x8", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    // add x9,x8,x0 : one stall, then forward from stage 1
    drive(1, 5'd8, 1, 5'd0, 1, 5'd9, 1, 0, 0);
    expect_out("lu_stall", 1, 0, 0, RF1, 1, 0, RF2);
    sample();
    expect_out("lu_resume", 0, 0, 2, 32'h0000_ABCD, 0, 0, RF2);
    sample();

    // jump: flush for two cycles, two bubbles into the tracker
    drive(1, 5'd9, 1, 5'd0, 0, 5'd13, 1, 0, 1);
    expect_out("jump0", 0, 1, 1, S0, 0, 0, RF2);
    sample();
    drive(1, 5'd9, 1, 5'd0, 0, 5'd14, 1, 0, 0);
    expect_out("jump1", 0, 1, 2, 32'h0000_ABCD, 0, 0, RF2);
    sample();
    drive(1, 5'd13, 1, 5'd14, 1, 5'd15, 1, 0, 0);
    expect_out("post_jump", 0, 0, 0, RF1, 0, 0, RF2);
    sample();

    // jump during a load-use stall: flush wins
    drive(1, 5'd0, 0, 5'd0, 0, 5'd16, 1, 1, 0);
    expect_out("lw_x16", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    drive(1, 5'd16, 1, 5'd0, 0, 5'd17, 1, 0, 1);
    expect_out("lu_jump", 0, 1, 0, RF1, 1, 0, RF2);
    sample();
    drive(1, 5'd16, 1, 5'd0, 0, 5'd17, 1, 0, 0);
    expect_out("lu_jump1", 0, 1, 2, 32'h0000_ABCD, 0, 0, RF2);
    sample();

    // two valid entries, then asynchronous reset mid-cycle
    drive(1, 5'd0, 0, 5'd0, 0, 5'd20, 1, 0, 0);
    expect_out("wr_x20", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    drive(1, 5'd0, 0, 5'd0, 0, 5'd21, 1, 0, 0);
    expect_out("wr_x21", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    drive(1, 5'd21, 1, 5'd20, 1, 5'd22, 1, 0, 0);
    #1;
    rst = 1'b1;
    expect_out("mid_reset", 0, 0, 0, RF1, 0, 0, RF2);
    sample();
    rst = 1'b0;
    drive(1, 5'd21, 1, 5'd20, 1, 5'd22, 1, 0, 0);
    expect_out("post_reset", 0, 0, 0, RF1, 0, 0, RF2);
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
